// File: rtl/krnl_vadd_rtl_ctrl_seq.sv
// Kernel sequencer: turns a level ap_start into one launch of all masters and reports ap_idle/ap_done.
// ap_start to start pulses is 1 cycle and last done to ap_done is 1 cycle; there is no backpressure, and done pulses outside a run are ignored.
module krnl_vadd_rtl_ctrl_seq #(
    parameter int C_NUM_RD     = 4,
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_LEN_WIDTH  = 32
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             ap_start,
    output logic                             ap_idle,
    output logic                             ap_done,
    input  logic [C_NUM_RD*C_ADDR_WIDTH-1:0] rd_ptr,
    input  logic [C_ADDR_WIDTH-1:0]          wr_ptr,
    input  logic [C_LEN_WIDTH-1:0]           xfer_bytes,
    output logic [C_NUM_RD-1:0]              rd_start,
    output logic [C_NUM_RD*C_ADDR_WIDTH-1:0] rd_addr,
    input  logic [C_NUM_RD-1:0]              rd_done,
    output logic                             wr_start,
    output logic [C_ADDR_WIDTH-1:0]          wr_addr,
    input  logic                             wr_done,
    output logic [C_LEN_WIDTH-1:0]           xfer_len,
    output logic [31:0]                      busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [C_NUM_RD-1:0] rd_flag;
    logic                wr_flag;
    logic [C_NUM_RD-1:0] rd_seen;
    logic                wr_seen;
    logic                all_seen;
    logic                sampling;
    logic                accept;

    assign sampling = (state == S_LAUNCH) || (state == S_BUSY);
    assign accept   = (state == S_IDLE) && ap_start;
    // A done pulse arriving this cycle counts as already set, so simultaneous finishes complete at once.
    assign rd_seen  = rd_flag | rd_done;
    assign wr_seen  = wr_flag | wr_done;
    assign all_seen = (&rd_seen) & wr_seen;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt = (xfer_bytes == '0) ? S_DONE : S_LAUNCH;
                end
            end
            S_LAUNCH, S_BUSY: begin
                state_nxt = all_seen ? S_DONE : S_BUSY;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ap_idle  = (state == S_IDLE);
        ap_done  = (state == S_DONE);
        rd_start = {C_NUM_RD{state == S_LAUNCH}};
        wr_start = (state == S_LAUNCH);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_addr     <= '0;
            wr_addr     <= '0;
            xfer_len    <= '0;
            rd_flag     <= '0;
            wr_flag     <= 1'b0;
            busy_cycles <= '0;
        end else if (accept) begin
            rd_addr     <= rd_ptr;
            wr_addr     <= wr_ptr;
            xfer_len    <= xfer_bytes;
            rd_flag     <= '0;
            wr_flag     <= 1'b0;
            busy_cycles <= '0;
        end else if (sampling) begin
            rd_flag <= rd_seen;
            wr_flag <= wr_seen;
            if (busy_cycles != 32'hFFFF_FFFF) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_krnl_vadd_rtl_ctrl_seq.sv
// Bench for krnl_vadd_rtl_ctrl_seq: run-level timeline model checked every cycle, plus literal anchors.
module tb_krnl_vadd_rtl_ctrl_seq;
    localparam int NRD = 4;
    localparam int AW  = 64;
    localparam int LW  = 32;
    localparam int TAB = 8192;

    logic                aclk = 1'b0;
    logic                areset = 1'b1;
    logic                ap_start = 1'b0;
    logic                ap_idle, ap_done;
    logic [NRD*AW-1:0]   rd_ptr = '0;
    logic [AW-1:0]       wr_ptr = '0;
    logic [LW-1:0]       xfer_bytes = '0;
    logic [NRD-1:0]      rd_start;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_done = '0;
    logic                wr_start;
    logic [AW-1:0]       wr_addr;
    logic                wr_done = 1'b0;
    logic [LW-1:0]       xfer_len;
    logic [31:0]         busy_cycles;

    krnl_vadd_rtl_ctrl_seq #(.C_NUM_RD(NRD), .C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)) dut (
        .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .xfer_bytes(xfer_bytes), .rd_start(rd_start),
        .rd_addr(rd_addr), .rd_done(rd_done), .wr_start(wr_start), .wr_addr(wr_addr),
        .wr_done(wr_done), .xfer_len(xfer_len), .busy_cycles(busy_cycles)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic          idle;
        logic          done;
        logic [3:0]    rs;
        logic          ws;
        logic [255:0]  ra;
        logic [63:0]   wa;
        logic [31:0]   len;
        logic [31:0]   busy;
    } exp_t;

    exp_t tab [TAB];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   done_cnt = 0, start_cnt = 0, last_done_cyc = -1, last_start_cyc = -1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.idle = 1'b1; e.done = 1'b0; e.rs = '0; e.ws = 1'b0;
        e.ra = '0; e.wa = '0; e.len = '0; e.busy = '0;
        return e;
    endfunction

    task automatic fill(input int from, input int to, input exp_t e);
        for (int c = from; c <= to && c < TAB; c++) tab[c] = e;
    endtask

    function automatic logic [255:0] r256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Per-cycle comparison against the expected timeline.
    always @(negedge aclk) begin
        if (chk_en) begin
            if (cyc >= TAB) begin
                errors++;
                $display("FAIL cycle_budget: cycle %0d beyond table size %0d", cyc, TAB);
            end else begin
                chk("ap_idle", ap_idle, tab[cyc].idle);
                chk("ap_done", ap_done, tab[cyc].done);
                chk("rd_start", rd_start, tab[cyc].rs);
                chk("wr_start", wr_start, tab[cyc].ws);
                chk("rd_addr", rd_addr, tab[cyc].ra);
                chk("wr_addr", wr_addr, tab[cyc].wa);
                chk("xfer_len", xfer_len, tab[cyc].len);
                chk("busy_cycles", busy_cycles, tab[cyc].busy);
            end
        end
    end

    always @(negedge aclk) begin
        if (ap_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (wr_start === 1'b1 || |rd_start) begin
            start_cnt++;
            last_start_cyc = cyc;
        end
    end

    // One run: accepted at cycle n; done delays dl[0..3] (read) and dl[4] (write) count from LAUNCH.
    task automatic do_run(input logic [31:0] len, input logic [255:0] rp, input logic [63:0] wp,
                          input int dl[5], input bit b2b, input bit dup, input bit perturb,
                          output int n_o);
        int   n, m, mx;
        exp_t e;
        n = cyc;
        ap_start = 1'b1; rd_ptr = rp; wr_ptr = wp; xfer_bytes = len;
        rd_done = '0; wr_done = 1'b0;
        mx = 0;
        for (int i = 0; i < 5; i++) if (dl[i] > mx) mx = dl[i];
        m = (len == 0) ? n : n + 1 + mx;
        for (int c = n + 1; c <= m + 1; c++) begin
            e.idle = 1'b0;
            e.done = (c == m + 1);
            e.rs   = (c == n + 1 && len != 0) ? 4'hF : 4'h0;
            e.ws   = (c == n + 1 && len != 0);
            e.ra = rp; e.wa = wp; e.len = len;
            e.busy = ((c - n - 1) < (m - n)) ? (c - n - 1) : (m - n);
            if (c < TAB) tab[c] = e;
        end
        e.idle = 1'b1; e.done = 1'b0; e.rs = '0; e.ws = 1'b0; e.busy = m - n;
        fill(m + 2, TAB - 1, e);
        for (int k = n + 1; k <= m + 2; k++) begin
            @(negedge aclk);
            rd_done = '0; wr_done = 1'b0;
            if (k <= m + 1 && len != 0) begin
                for (int i = 0; i < NRD; i++) if (k == n + 1 + dl[i]) rd_done[i] = 1'b1;
                if (dup && k == n + 2 + dl[2]) rd_done[2] = 1'b1;
                wr_done = (k == n + 1 + dl[4]);
            end
            if (perturb && k == n + 2) begin
                rd_ptr = r256(); wr_ptr = {$urandom, $urandom}; xfer_bytes = $urandom;
            end
            if (k == m + 2) ap_start = b2b;
        end
        n_o = n;
    endtask

    task automatic idle_cycles(input int k, input bit noise);
        repeat (k) begin
            @(negedge aclk);
            rd_done = noise ? 4'($urandom) : '0;
            wr_done = noise ? 1'($urandom) : 1'b0;
        end
    endtask

    task automatic reset_mid_run();
        int   n, dc;
        exp_t e;
        logic [255:0] rp;
        logic [63:0]  wp;
        n = cyc; dc = done_cnt;
        rp = r256(); wp = {$urandom, $urandom};
        ap_start = 1'b1; rd_ptr = rp; wr_ptr = wp; xfer_bytes = 32'd64;
        rd_done = '0; wr_done = 1'b0;
        for (int c = n + 1; c <= n + 5; c++) begin
            e.idle = 1'b0; e.done = 1'b0;
            e.rs = (c == n + 1) ? 4'hF : 4'h0; e.ws = (c == n + 1);
            e.ra = rp; e.wa = wp; e.len = 32'd64; e.busy = c - n - 1;
            tab[c] = e;
        end
        fill(n + 6, TAB - 1, reset_exp());
        repeat (5) @(negedge aclk);
        #1 areset = 1'b1;
        #1;
        ap_start = 1'b0;
        chk("rst_ap_idle", ap_idle, 1'b1);
        chk("rst_ap_done", ap_done, 1'b0);
        chk("rst_rd_start", rd_start, 4'h0);
        chk("rst_wr_start", wr_start, 1'b0);
        chk("rst_rd_addr", rd_addr, 256'h0);
        chk("rst_wr_addr", wr_addr, 64'h0);
        chk("rst_xfer_len", xfer_len, 32'h0);
        chk("rst_busy", busy_cycles, 32'h0);
        @(negedge aclk);
        @(negedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_no_ap_done", done_cnt, dc);
    endtask

    initial begin
        int n, n2, s0, d0, d1;
        int dl[5];
        bit b2b;
        for (int c = 0; c < TAB; c++) tab[c] = reset_exp();
        chk_en = 1'b1;
        repeat (3) @(negedge aclk);
        chk("init_ap_idle", ap_idle, 1'b1);
        chk("init_ap_done", ap_done, 1'b0);
        chk("init_busy", busy_cycles, 32'h0);
        #1 areset = 1'b0;
        @(negedge aclk);

        // Basic staggered run
        s0 = start_cnt;
        dl = '{3, 5, 7, 9, 20};
        do_run(32'd256, {64'h4000, 64'h3000, 64'h2000, 64'h1000}, 64'h5000, dl, 1'b0, 1'b0, 1'b0, n);
        chk("basic_busy", busy_cycles, 32'd21);
        chk("basic_done_cyc", last_done_cyc, n + 22);
        chk("basic_start_cnt", start_cnt - s0, 1);
        chk("basic_rd_addr", rd_addr, {64'h4000, 64'h3000, 64'h2000, 64'h1000});
        chk("basic_wr_addr", wr_addr, 64'h5000);
        chk("basic_xfer_len", xfer_len, 32'd256);
        idle_cycles(2, 1'b1);

        // Simultaneous done, two cycles after LAUNCH
        d0 = done_cnt;
        dl = '{2, 2, 2, 2, 2};
        do_run(32'd128, r256(), 64'h77, dl, 1'b0, 1'b0, 1'b0, n);
        chk("simul_done_cnt", done_cnt - d0, 1);
        chk("simul_done_cyc", last_done_cyc, n + 4);
        idle_cycles(1, 1'b0);

        // Minimum run
        dl = '{1, 1, 1, 1, 1};
        do_run(32'd4, r256(), 64'h88, dl, 1'b0, 1'b0, 1'b0, n);
        chk("min_busy", busy_cycles, 32'd2);
        chk("min_done_cyc", last_done_cyc, n + 3);
        idle_cycles(1, 1'b1);

        // Zero length
        s0 = start_cnt;
        do_run(32'd0, r256(), 64'h99, dl, 1'b0, 1'b0, 1'b0, n);
        chk("zero_start_cnt", start_cnt - s0, 0);
        chk("zero_done_cyc", last_done_cyc, n + 1);
        chk("zero_busy", busy_cycles, 32'd0);
        idle_cycles(2, 1'b0);

        // Stability: inputs perturbed mid-run and a duplicate rd_done[2]
        dl = '{2, 6, 3, 8, 10};
        do_run(32'd512, {64'hD, 64'hC, 64'hB, 64'hA}, 64'hE, dl, 1'b0, 1'b1, 1'b1, n);
        chk("stab_done_cyc", last_done_cyc, n + 12);
        chk("stab_rd_addr", rd_addr, {64'hD, 64'hC, 64'hB, 64'hA});
        chk("stab_xfer_len", xfer_len, 32'd512);
        idle_cycles(1, 1'b0);

        // Reset in BUSY, then a normal run
        reset_mid_run();
        dl = '{4, 3, 2, 5, 6};
        do_run(32'd1024, r256(), 64'h123, dl, 1'b0, 1'b0, 1'b0, n);
        chk("post_rst_busy", busy_cycles, 32'd7);
        idle_cycles(1, 1'b0);

        // Back-to-back with ap_start held through DONE
        dl = '{1, 2, 3, 4, 2};
        do_run(32'd64, r256(), 64'h1, dl, 1'b1, 1'b0, 1'b0, n);
        d1 = last_done_cyc;
        dl = '{3, 1, 1, 1, 1};
        do_run(32'd96, r256(), 64'h2, dl, 1'b0, 1'b0, 1'b0, n2);
        chk("b2b_launch_cyc", last_start_cyc, d1 + 2);
        chk("b2b_busy", busy_cycles, 32'd4);

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 5; i++) dl[i] = $urandom_range(1, 20);
            b2b = ($urandom_range(0, 3) == 0) && (r != 23);
            do_run(($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, r256(), {$urandom, $urandom},
                   dl, b2b, 1'($urandom), 1'($urandom), n);
            if (!b2b) idle_cycles($urandom_range(0, 3), 1'b1);
        end
        idle_cycles(3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/krnl_vadd_rtl_ctrl_seq.md
# krnl_vadd_rtl_ctrl_seq

Kernel sequencer for the 4-input/1-output vadd RTL kernel. It sits between the AXI4-Lite control register block and the memory masters. It turns the level `ap_start` from the control block into one launch of every read master and the write master, with latched addresses and length. It then collects the per-master done pulses and returns the `ap_idle`/`ap_done` status the control block expects, plus a cycle count of the last run.

## Interface
- `C_NUM_RD`, default 4, number of read masters (input streams).
- `C_ADDR_WIDTH`, default 64, width of each buffer pointer.
- `C_LEN_WIDTH`, default 32, width of the transfer length in bytes.

Ports:
- `aclk` in 1: kernel clock; single clock domain.
- `areset` in 1: asynchronous, active-high reset.
- `ap_start` in 1: level from the control register block; held high until `ap_done`.
- `ap_idle` out 1: high when the sequencer is in IDLE.
- `ap_done` out 1: one-cycle pulse at run completion.
- `rd_ptr` in C_NUM_RD*C_ADDR_WIDTH: read buffer pointers; channel i occupies `[i*C_ADDR_WIDTH +: C_ADDR_WIDTH]`.
- `wr_ptr` in C_ADDR_WIDTH: write buffer pointer.
- `xfer_bytes` in C_LEN_WIDTH: run length in bytes.
- `rd_start` out C_NUM_RD: one-cycle start pulse, one bit per read master.
- `rd_addr` out C_NUM_RD*C_ADDR_WIDTH: latched read pointers.
- `rd_done` in C_NUM_RD: one-cycle done pulse from each read master.
- `wr_start` out 1: one-cycle start pulse to the write master.
- `wr_addr` out C_ADDR_WIDTH: latched write pointer.
- `wr_done` in 1: one-cycle done pulse from the write master.
- `xfer_len` out C_LEN_WIDTH: latched length.
- `busy_cycles` out 32: cycles spent in LAUNCH+BUSY during the last run.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, DONE. Encoding is free; all outputs decode from registered state or registered values, with no input-to-output combinational path.
- IDLE:
  - `ap_idle`=1.
  - If `ap_start`=1, latch `rd_ptr`, `wr_ptr` and `xfer_bytes` into `rd_addr`, `wr_addr` and `xfer_len`.
  - Clear the done flags and clear `busy_cycles`.
  - Go to LAUNCH, or go directly to DONE if `xfer_bytes`==0. No starts are issued for a zero-length run.
- LAUNCH:
  - `rd_start` = all ones and `wr_start` = 1 for exactly this cycle.
  - Go to BUSY.
- BUSY:
  - There is one sticky flag per read channel plus one for write. A flag sets on its done pulse.
  - Done pulses are sampled in LAUNCH and BUSY only and ignored in IDLE and DONE.
  - Go to DONE in the cycle after every flag is set. A final done arriving in the same cycle as other flags counts, so all-simultaneous done pulses give the same result.
  - Duplicate done pulses on an already-set flag have no effect.
- DONE:
  - `ap_done`=1 for exactly this cycle.
  - Go to IDLE unconditionally.
  - The control block clears `ap_start` on `ap_done`, so no relaunch occurs. If `ap_start` is still high in the following IDLE cycle, a new run is launched; this is legal back-to-back behaviour.
- `busy_cycles`:
  - Increments by 1 in each LAUNCH and BUSY cycle.
  - Saturates at 32'hFFFF_FFFF.
  - Holds its value through DONE and IDLE until the next launch.
- Latched `rd_addr`/`wr_addr`/`xfer_len` hold stable from LAUNCH until the next accepted `ap_start`. Input changes during a run are ignored.
- Reset values (applied asynchronously on `areset`; the FSM state resets to IDLE):
  - `ap_idle`=1
  - `ap_done`=0
  - `rd_start`=0
  - `wr_start`=0
  - all latched addresses, `xfer_len`, flags and `busy_cycles` = 0
- Reset asserted mid-run aborts the run with no `ap_done`. Masters are reset by the same `areset`.

## Timing
- `ap_start` sampled high in IDLE at cycle N:
  - `ap_idle` falls and LAUNCH is active at N+1.
  - `rd_start`/`wr_start` are high at N+1 only.
- The last outstanding done pulse at cycle M (M ≥ N+1) gives `ap_done` high at M+1 and `ap_idle` high at M+2.
- Minimum run (all done pulses at N+2): `ap_done` at N+3 and `busy_cycles`=2.
- A zero-length run gives `ap_done` at N+1, `busy_cycles`=0, and no start pulses.
- There is no throughput limit between runs beyond one IDLE cycle.

## Test plan
- Basic run: `xfer_bytes`=256, ptrs 0x1000/0x2000/0x3000/0x4000/0x5000. Stagger `rd_done` at +3,+5,+7,+9 cycles and `wr_done` at +20 cycles after LAUNCH. Required: a single start pulse on every output, addresses latched, `ap_done` 1 cycle after `wr_done`, `busy_cycles`=21.
- Simultaneous done: all five done pulses in the same cycle, two cycles after LAUNCH. Required: `ap_done` the next cycle, exactly once.
- Zero length: `xfer_bytes`=0. Required: `rd_start`/`wr_start` never assert, `ap_done` at N+1, `busy_cycles`=0.
- Stability: change `rd_ptr` and `xfer_bytes` mid-run, and send a duplicate `rd_done[2]` before the others complete. Required: latched outputs unchanged, completion still waits for all five flags.
- Reset mid-BUSY: assert `areset` asynchronously between clock edges. Required: immediate `ap_idle`=1, all other outputs 0, no `ap_done`. A subsequent run completes normally.
- Back-to-back: hold `ap_start` high through DONE. Required: a second LAUNCH occurs after exactly one IDLE cycle, and `busy_cycles` restarts from 0.
